stopwatch_core: RTL and testbench

//   Consumer of the one-cycle enable pulses produced by the clock-enable generator.

---
 rtl/stopwatch_core_if.sv | 27 ++
 rtl/stopwatch_core.sv | 137 +++++++++++++
 tb/tb_stopwatch_core.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_core_if.sv
// Control and display signal bundle between the stopwatch core and its neighbours.
// The master drives enables, buttons and mode levels; the slave (core) drives the display.
interface stopwatch_core_if;
    logic       en_1hz;
    logic       en_2hz;
    logic       en_blink;
    logic       pause_pulse;
    logic       clr_pulse;
    logic       adj;
    logic       sel;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       paused;
    logic [3:0] digit_blank;

    modport master (
        output en_1hz, en_2hz, en_blink, pause_pulse, clr_pulse, adj, sel,
        input  min_tens, min_ones, sec_tens, sec_ones, paused, digit_blank
    );

    modport slave (
        input  en_1hz, en_2hz, en_blink, pause_pulse, clr_pulse, adj, sel,
        output min_tens, min_ones, sec_tens, sec_ones, paused, digit_blank
    );
endinterface

// File: rtl/stopwatch_core.sv
// MM:SS BCD stopwatch with a run/pause/adjust FSM and adjust-mode digit blinking.
// All timing comes from single-cycle enable pulses in the clk_100mhz domain.
module stopwatch_core #(
    parameter int unsigned MIN_MAX = 99,
    parameter int unsigned SEC_MAX = 59
) (
    input  logic             clk_100mhz,
    input  logic             rst_n,
    stopwatch_core_if.slave  sw
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_ADJUST = 2'd2
    } state_t;

    typedef struct packed {
        logic       carry;
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_pair_t;

    // Any pattern at or beyond the field maximum (or an illegal digit) wraps to 00;
    // only the exact maximum produces a carry.
    function automatic bcd_pair_t bcd_inc(input logic [3:0] tens, input logic [3:0] ones,
                                          input int unsigned max_val);
        bcd_pair_t  res;
        logic [3:0] max_t;
        logic [3:0] max_o;
        max_t = 4'(max_val / 10);
        max_o = 4'(max_val % 10);
        res   = '0;
        if (ones > 4'd9 || tens > max_t || (tens == max_t && ones >= max_o)) begin
            res.carry = (tens == max_t && ones == max_o);
        end else if (ones == 4'd9) begin
            res.tens = tens + 4'd1;
        end else begin
            res.tens = tens;
            res.ones = ones + 4'd1;
        end
        return res;
    endfunction

    state_t     state_q, state_d;
    logic [3:0] min_t_q, min_o_q, sec_t_q, sec_o_q;
    logic [3:0] min_t_d, min_o_d, sec_t_d, sec_o_d;
    logic       paused_q, paused_d;
    logic       blink_q, blink_d;
    logic [3:0] blank_q, blank_d;
    bcd_pair_t  sec_inc, min_inc;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d  = state_q;
        paused_d = paused_q;
        min_t_d  = min_t_q;
        min_o_d  = min_o_q;
        sec_t_d  = sec_t_q;
        sec_o_d  = sec_o_q;
        sec_inc  = bcd_inc(sec_t_q, sec_o_q, SEC_MAX);
        min_inc  = bcd_inc(min_t_q, min_o_q, MIN_MAX);

        unique case (state_q)
            ST_RUN: begin
                if (sw.adj) begin
                    state_d = ST_ADJUST;
                end else if (sw.pause_pulse) begin
                    state_d  = ST_PAUSED;
                    paused_d = 1'b1;
                end
                if (sw.en_1hz) begin
                    {sec_t_d, sec_o_d} = {sec_inc.tens, sec_inc.ones};
                    if (sec_inc.carry) {min_t_d, min_o_d} = {min_inc.tens, min_inc.ones};
                end
            end
            ST_PAUSED: begin
                if (sw.adj) begin
                    state_d = ST_ADJUST;
                end else if (sw.pause_pulse) begin
                    state_d  = ST_RUN;
                    paused_d = 1'b0;
                end
            end
            ST_ADJUST: begin
                if (sw.pause_pulse) paused_d = ~paused_q;
                if (!sw.adj) state_d = paused_d ? ST_PAUSED : ST_RUN;
                // Fields adjust independently: no carry from seconds into minutes.
                if (sw.en_2hz) begin
                    if (sw.sel) {sec_t_d, sec_o_d} = {sec_inc.tens, sec_inc.ones};
                    else        {min_t_d, min_o_d} = {min_inc.tens, min_inc.ones};
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (sw.clr_pulse) begin
            {min_t_d, min_o_d, sec_t_d, sec_o_d} = '0;
        end

        // Blink phase only runs while staying in ADJUST, so entry always starts visible.
        blink_d = (state_q == ST_ADJUST && state_d == ST_ADJUST) ? (blink_q ^ sw.en_blink) : 1'b0;
        blank_d = '0;
        if (state_d == ST_ADJUST && blink_d) blank_d = sw.sel ? 4'b0011 : 4'b1100;
    end

    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk_100mhz) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            min_t_q  <= '0;
            min_o_q  <= '0;
            sec_t_q  <= '0;
            sec_o_q  <= '0;
            paused_q <= 1'b0;
            blink_q  <= 1'b0;
            blank_q  <= '0;
        end else begin
            state_q  <= state_d;
            min_t_q  <= min_t_d;
            min_o_q  <= min_o_d;
            sec_t_q  <= sec_t_d;
            sec_o_q  <= sec_o_d;
            paused_q <= paused_d;
            blink_q  <= blink_d;
            blank_q  <= blank_d;
        end
    end

    assign sw.min_tens    = min_t_q;
    assign sw.min_ones    = min_o_q;
    assign sw.sec_tens    = sec_t_q;
    assign sw.sec_ones    = sec_o_q;
    assign sw.paused      = paused_q;
    assign sw.digit_blank = blank_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: an integer MM:SS model feeds a scoreboard queue
// that is compared against the registered outputs one cycle after each stimulus.
module tb_stopwatch_core;

    logic clk = 1'b0;
    logic rst_n;

    stopwatch_core_if sw_if ();

    stopwatch_core #(
        .MIN_MAX (99),
        .SEC_MAX (59)
    ) dut (
        .clk_100mhz (clk),
        .rst_n      (rst_n),
        .sw         (sw_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        int         mn;
        int         sc;
        logic       p;
        logic [3:0] blank;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    int         m_min   = 0;
    int         m_sec   = 0;
    logic       m_pause = 1'b0;
    logic [3:0] m_blank = 4'b0000;

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag   = tag;
        e.mn    = m_min;
        e.sc    = m_sec;
        e.p     = m_pause;
        e.blank = m_blank;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t        e;
        logic [17:0] obs;
        logic [17:0] req;
        n_checks++;
        if (sb.size() == 0) begin
            n_errors++;
            $error("FAIL scoreboard_empty: no expected entry");
            return;
        end
        e   = sb.pop_front();
        req = {4'(e.mn / 10), 4'(e.mn % 10), 4'(e.sc / 10), 4'(e.sc % 10), e.p, e.blank[0]};
        obs = {sw_if.min_tens, sw_if.min_ones, sw_if.sec_tens, sw_if.sec_ones,
               sw_if.paused, sw_if.digit_blank[0]};
        assert (obs === req && sw_if.digit_blank === e.blank) else begin
            n_errors++;
            $error("FAIL %s: observed %h%h:%h%h paused=%b blank=%b expected %0d:%0d paused=%b blank=%b",
                   e.tag, sw_if.min_tens, sw_if.min_ones, sw_if.sec_tens, sw_if.sec_ones,
                   sw_if.paused, sw_if.digit_blank, e.mn, e.sc, e.p, e.blank);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        sw_if.en_1hz      = 1'b0;
        sw_if.en_2hz      = 1'b0;
        sw_if.en_blink    = 1'b0;
        sw_if.pause_pulse = 1'b0;
        sw_if.clr_pulse   = 1'b0;
    endtask

    task automatic step(input string tag);
        push_exp(tag);
        tick();
        check();
    endtask

    task automatic model_run_inc();
        m_sec++;
        if (m_sec == 60) begin
            m_sec = 0;
            m_min = (m_min + 1) % 100;
        end
    endtask

    task automatic adj_min(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            sw_if.en_2hz = 1'b1;
            m_min = (m_min + 1) % 100;
            step(tag);
        end
    endtask

    task automatic adj_sec(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            sw_if.en_2hz = 1'b1;
            m_sec = (m_sec + 1) % 60;
            step(tag);
        end
    endtask

    task automatic run_ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            sw_if.en_1hz = 1'b1;
            model_run_inc();
            step(tag);
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n             = 1'b0;
        sw_if.en_1hz      = 1'b0;
        sw_if.en_2hz      = 1'b0;
        sw_if.en_blink    = 1'b0;
        sw_if.pause_pulse = 1'b0;
        sw_if.clr_pulse   = 1'b0;
        sw_if.adj         = 1'b0;
        sw_if.sel         = 1'b0;
        #1;

        // 1) reset, then three run ticks with one-cycle latency and hold afterwards
        step("reset_0");
        step("reset_1");
        rst_n = 1'b1;
        step("reset_release");
        for (int i = 0; i < 3; i++) begin
            sw_if.en_1hz = 1'b1;
            model_run_inc();
            step("run_inc");
            step("run_hold");
        end

        // 2) preload 00:59 via ADJUST, carry into minutes; preload 99:59, full wrap
        sw_if.adj = 1'b1;
        sw_if.sel = 1'b1;
        step("adj_enter");
        adj_sec(56, "preload_sec");
        sw_if.adj = 1'b0;
        step("adj_exit");
        run_ticks(1, "sec_carry_to_min");
        sw_if.adj = 1'b1;
        sw_if.sel = 1'b0;
        step("adj_enter2");
        adj_min(98, "preload_min99");
        sw_if.sel = 1'b1;
        adj_sec(59, "preload_sec59");
        sw_if.adj = 1'b0;
        step("adj_exit2");
        run_ticks(1, "wrap_9959");

        // 3) pause together with a tick, hold while paused, resume
        run_ticks(10, "run_to_10");
        sw_if.pause_pulse = 1'b1;
        sw_if.en_1hz      = 1'b1;
        model_run_inc();
        m_pause = 1'b1;
        step("pause_with_tick");
        for (int i = 0; i < 5; i++) begin
            sw_if.en_1hz = 1'b1;
            step("paused_hold_1hz");
        end
        sw_if.en_2hz = 1'b1;
        step("paused_hold_2hz");
        sw_if.pause_pulse = 1'b1;
        m_pause = 1'b0;
        step("resume");
        run_ticks(1, "run_after_resume");

        // 4) field-local adjust wrap with no carry; 1 Hz ignored in ADJUST
        sw_if.adj = 1'b1;
        sw_if.sel = 1'b0;
        step("adj_enter3");
        adj_min(5, "adj_min_to_05");
        sw_if.sel = 1'b1;
        adj_sec(46, "adj_sec_to_58");
        adj_sec(3, "adj_sec_nocarry");
        sw_if.sel = 1'b0;
        adj_min(94, "adj_min_to_99");
        adj_min(1, "adj_min_wrap");
        sw_if.en_1hz = 1'b1;
        step("adj_ignore_1hz");

        // 5) blink mask follows sel; leaving ADJUST clears it
        sw_if.en_blink = 1'b1;
        m_blank = 4'b1100;
        step("blink_min_on");
        sw_if.en_blink = 1'b1;
        m_blank = 4'b0000;
        step("blink_min_off");
        sw_if.sel = 1'b1;
        step("blink_sel_change");
        sw_if.en_blink = 1'b1;
        m_blank = 4'b0011;
        step("blink_sec_on");
        sw_if.adj = 1'b0;
        m_blank = 4'b0000;
        step("blink_exit");

        // 6) clear beats a same-cycle tick and keeps RUN; pause inside ADJUST; reset mid-blink
        sw_if.adj = 1'b1;
        sw_if.sel = 1'b0;
        step("adj_enter4");
        adj_min(12, "preload_12");
        sw_if.sel = 1'b1;
        adj_sec(33, "preload_34");
        sw_if.adj = 1'b0;
        step("adj_exit4");
        sw_if.clr_pulse = 1'b1;
        sw_if.en_1hz    = 1'b1;
        m_min = 0;
        m_sec = 0;
        step("clr_beats_tick");
        run_ticks(1, "run_after_clr");
        sw_if.adj = 1'b1;
        step("adj_enter5");
        sw_if.pause_pulse = 1'b1;
        m_pause = 1'b1;
        step("adj_pause_toggle");
        sw_if.adj = 1'b0;
        step("adj_exit_paused");
        sw_if.en_1hz = 1'b1;
        step("paused_after_adj");
        sw_if.adj = 1'b1;
        step("adj_enter6");
        sw_if.en_blink = 1'b1;
        m_blank = 4'b0011;
        step("blink_before_reset");
        rst_n = 1'b0;
        sw_if.en_2hz = 1'b1;
        m_min   = 0;
        m_sec   = 0;
        m_pause = 1'b0;
        m_blank = 4'b0000;
        step("reset_in_adjust");
        rst_n     = 1'b1;
        sw_if.adj = 1'b0;
        step("post_reset_idle");
        run_ticks(1, "post_reset_run");

        if (sb.size() != 0) begin
            n_errors++;
            $error("FAIL scoreboard_leftover: %0d entries remain, 0 required", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
